pc_sequencer_fsm: RTL and testbench

- Multicycle control FSM that sequences instruction fetch and PC updates for the MIPS-subset core.
- Drives the PC-update inputs (pc_write, isBEQ, isBNE) and the PC mux select. The existing branch-combine logic turns these into the final PC write enable.
- Starts the datapath execute control for non-control-flow instructions and waits for it to finish.

---
 rtl/pc_seq_pkg.sv | 51 +++++
 rtl/pc_seq_wait_cnt.sv | 37 +++
 rtl/pc_sequencer_fsm.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer_fsm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: state encoding, MIPS
// opcode/funct values and PC mux select codes. The EXCEPT state exists only
// when PC_SEQ_EXCEPTION_EN is defined.
package pc_seq_pkg;

    typedef enum logic [3:0] {
        S_RST        = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_DONE = 4'd2,
        S_DECODE     = 4'd3,
        S_BRANCH     = 4'd4,
        S_JUMP       = 4'd5,
        S_JREG       = 4'd6,
        S_EXEC       = 4'd7,
        S_EXEC_WAIT  = 4'd8
`ifdef PC_SEQ_EXCEPTION_EN
        , S_EXCEPT   = 4'd9
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam int PC_SRC_W = 3;
    localparam logic [PC_SRC_W-1:0] PC_SRC_PC4    = 3'd0;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 3'd1;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 3'd2;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JR     = 3'd3;
    localparam logic [PC_SRC_W-1:0] PC_SRC_EXC    = 3'd4;

    // Non-R-type opcodes that are handed to the execute controller.
    function automatic logic is_exec_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_seq_wait_cnt.sv
// Instruction-memory wait counter. Counts FETCH cycles and flags the last one
// (count == MEM_WAIT_CYCLES-1); clear has priority over increment.
module pc_seq_wait_cnt #(
    parameter int CNT_W           = 4,
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise step while fetching.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, zeroed by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(MEM_WAIT_CYCLES - 1));

endmodule

// File: rtl/pc_sequencer_fsm.sv
// Multicycle fetch / PC-update sequencer for the MIPS-subset core.
// Moore FSM: every output decodes from registered state only. Opcode-dependent
// outputs in BRANCH/JUMP use flags captured in DECODE.
// Optional macro PC_SEQ_EXCEPTION_EN adds the EXCEPT state and epc_write port;
// without it illegal opcodes behave as a NOP.
// Handshake: exec_start is a one-cycle pulse; the FSM then waits in EXEC_WAIT
// for a one-cycle exec_done pulse (exec_done is ignored in every other state).
module pc_sequencer_fsm
    import pc_seq_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int CNT_W           = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                exec_done,
    output logic                mem_read,
    output logic                ir_write,
    output logic                pc_write,
    output logic                isBEQ,
    output logic                isBNE,
    output logic [PC_SRC_W-1:0] pc_source,
    output logic                br_calc,
    output logic                link_write,
    output logic                exec_start,
`ifdef PC_SEQ_EXCEPTION_EN
    output logic                epc_write,
`endif
    output state_t              dbg_state
);

    state_t state_q, state_d;
    logic   is_bne_q, is_bne_d;
    logic   is_jal_q, is_jal_d;
    logic   fetch_tc;

    pc_seq_wait_cnt #(
        .CNT_W           (CNT_W),
        .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES)
    ) u_wait_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (state_q == S_FETCH),
        .clr_i   ((state_q == S_FETCH) && fetch_tc),
        .tc_o    (fetch_tc)
    );

    // State and opcode-flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_RST;
            is_bne_q <= 1'b0;
            is_jal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_bne_q <= is_bne_d;
            is_jal_q <= is_jal_d;
        end
    end

    // Next-state logic and DECODE-time opcode flag capture.
    always_comb begin
        state_d  = state_q;
        is_bne_d = is_bne_q;
        is_jal_d = is_jal_q;
        case (state_q)
            S_RST:        state_d = S_FETCH;
            S_FETCH:      if (fetch_tc) state_d = S_FETCH_DONE;
            S_FETCH_DONE: state_d = S_DECODE;
            S_DECODE: begin
                is_bne_d = (opcode == OP_BNE);
                is_jal_d = (opcode == OP_JAL);
                if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_RTYPE) begin
                    state_d = (funct == FUNCT_JR) ? S_JREG : S_EXEC;
                end else if (is_exec_op(opcode)) begin
                    state_d = S_EXEC;
                end else begin
`ifdef PC_SEQ_EXCEPTION_EN
                    state_d = S_EXCEPT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_BRANCH:     state_d = S_FETCH;
            S_JUMP:       state_d = S_FETCH;
            S_JREG:       state_d = S_FETCH;
            S_EXEC:       state_d = S_EXEC_WAIT;
            S_EXEC_WAIT:  if (exec_done) state_d = S_FETCH;
`ifdef PC_SEQ_EXCEPTION_EN
            S_EXCEPT:     state_d = S_FETCH;
`endif
            default:      state_d = S_RST;
        endcase
    end

    // Moore output decode; everything idles at zero unless the state says so.
    always_comb begin
        mem_read   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        isBEQ      = 1'b0;
        isBNE      = 1'b0;
        pc_source  = PC_SRC_PC4;
        br_calc    = 1'b0;
        link_write = 1'b0;
        exec_start = 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
        epc_write  = 1'b0;
`endif
        case (state_q)
            S_FETCH: mem_read = 1'b1;
            S_FETCH_DONE: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: br_calc = 1'b1;
            S_BRANCH: begin
                pc_source = PC_SRC_BRANCH;
                isBEQ     = !is_bne_q;
                isBNE     = is_bne_q;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                link_write = is_jal_q;
            end
            S_JREG: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JR;
            end
            S_EXEC: exec_start = 1'b1;
`ifdef PC_SEQ_EXCEPTION_EN
            S_EXCEPT: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_source = PC_SRC_EXC;
            end
`endif
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer_fsm.sv
// Self-checking bench for pc_sequencer_fsm (MEM_WAIT_CYCLES = 2). Each
// instruction pushes its expected per-cycle output vectors into exp_q; the
// vectors are popped and compared on the falling edge of every cycle.
// Build with +define+PC_SEQ_EXCEPTION_EN to cover the exception path.
module tb_pc_sequencer_fsm;
    import pc_seq_pkg::*;

    localparam int M  = 2;
    localparam int VW = 12;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       exec_done = 1'b0;

    logic       mem_read, ir_write, pc_write, isBEQ, isBNE;
    logic [2:0] pc_source;
    logic       br_calc, link_write, exec_start, epc_write;
    state_t     dbg_state;

    always #5 clk = ~clk;

    pc_sequencer_fsm #(
        .MEM_WAIT_CYCLES (M),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .funct      (funct),
        .exec_done  (exec_done),
        .mem_read   (mem_read),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .isBEQ      (isBEQ),
        .isBNE      (isBNE),
        .pc_source  (pc_source),
        .br_calc    (br_calc),
        .link_write (link_write),
        .exec_start (exec_start),
`ifdef PC_SEQ_EXCEPTION_EN
        .epc_write  (epc_write),
`endif
        .dbg_state  (dbg_state)
    );

`ifndef PC_SEQ_EXCEPTION_EN
    assign epc_write = 1'b0;
`endif

    // {mem_read, ir_write, pc_write, isBEQ, isBNE, pc_source, br_calc, link_write, exec_start, epc_write}
    wire [VW-1:0] act_vec = {mem_read, ir_write, pc_write, isBEQ, isBNE, pc_source,
                             br_calc, link_write, exec_start, epc_write};

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [VW-1:0] v(input logic mr, input logic ir, input logic pw,
                                        input logic beq, input logic bne, input logic [2:0] src,
                                        input logic brc, input logic lnk, input logic es,
                                        input logic epc);
        return {mr, ir, pw, beq, bne, src, brc, lnk, es, epc};
    endfunction

    // 0 branch, 1 jump, 2 jr, 3 execute, 4 illegal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h04, 6'h05: return 0;
            6'h02, 6'h03: return 1;
            6'h00:        return (fn == 6'h08) ? 2 : 3;
            6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 3;
            default:      return 4;
        endcase
    endfunction

    // ---------------- driver / checker ----------------
    // Entered on the falling edge of the first FETCH cycle; returns on the
    // falling edge of the next instruction's first FETCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int n_wait,
                             input logic done_in_exec, input string name);
        int cls;
        int k;
        logic [VW-1:0] exp;
        opcode = op;
        funct  = fn;
        cls    = classify(op, fn);
        for (int i = 0; i < M; i++)
            exp_q.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        case (cls)
            0: exp_q.push_back(v(1'b0, 1'b0, 1'b0, op == 6'h04, op == 6'h05, 3'd1,
                                 1'b0, 1'b0, 1'b0, 1'b0));
            1: exp_q.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2,
                                 1'b0, op == 6'h03, 1'b0, 1'b0));
            2: exp_q.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
            3: begin
                exp_q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
                for (int i = 0; i < n_wait; i++) exp_q.push_back('0);
            end
            default: begin
`ifdef PC_SEQ_EXCEPTION_EN
                exp_q.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
            end
        endcase
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (act_vec !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, k, act_vec, exp);
            end
            // exec_done applies at the rising edge that ends cycle k
            exec_done = (cls == 3) && ((k == M + 2 + n_wait) || (done_in_exec && k == M + 2));
            @(negedge clk);
            k++;
        end
        exec_done = 1'b0;
        checks++;
        if (dbg_state !== S_FETCH || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL %s refetch: state got %0d expected %0d, mem_read got %b",
                     name, dbg_state, S_FETCH, mem_read);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (act_vec !== '0 || dbg_state !== S_RST) begin
            errors++;
            $display("FAIL reset_hold: outputs got %h state %0d expected 0 / RST", act_vec, dbg_state);
        end
        reset_n = 1'b1;
        checks++;
        if (act_vec !== '0 || dbg_state !== S_RST) begin
            errors++;
            $display("FAIL reset_rst_state: outputs got %h state %0d expected 0 / RST", act_vec, dbg_state);
        end
        @(negedge clk);
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 0, 1'b0, "beq");
        run_instr(6'h05, 6'h11, 0, 1'b0, "bne");
    endtask

    task automatic test_jump();
        run_instr(6'h03, 6'h00, 0, 1'b0, "jal");
        run_instr(6'h02, 6'h00, 0, 1'b0, "j");
        run_instr(6'h00, 6'h08, 0, 1'b0, "jr");
    endtask

    task automatic test_exec();
        run_instr(6'h23, 6'h00, 8, 1'b0, "lw_wait");
        run_instr(6'h00, 6'h20, 1, 1'b1, "add_done_in_exec");
        run_instr(6'h0f, 6'h00, $urandom_range(1, 5), 1'b0, "lui");
    endtask

    task automatic test_illegal();
        run_instr(6'h3f, 6'h00, 0, 1'b0, "illegal_3f");
        run_instr(6'h01, 6'h08, 0, 1'b0, "illegal_01");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h08, 6'h0c, 6'h0d, 6'h2b, 6'h09, 6'h3f};
        logic [5:0] fns[12] = '{6'h08, 6'h25, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        int idx;
        for (int i = 0; i < 10; i++) begin
            idx = $urandom_range(0, 11);
            run_instr(ops[idx], fns[idx], $urandom_range(1, 4), 1'b0, "b2b");
        end
    endtask

    task automatic test_reset_mid(input logic in_exec_wait, input string name);
        if (in_exec_wait) begin
            opcode = 6'h23;
            funct  = 6'h00;
            repeat (M + 3) @(negedge clk);
            checks++;
            if (dbg_state !== S_EXEC_WAIT) begin
                errors++;
                $display("FAIL %s pre_state: got %0d expected %0d", name, dbg_state, S_EXEC_WAIT);
            end
        end else begin
            checks++;
            if (mem_read !== 1'b1 || dbg_state !== S_FETCH) begin
                errors++;
                $display("FAIL %s pre_state: mem_read got %b state %0d expected 1 / FETCH",
                         name, mem_read, dbg_state);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (act_vec !== '0 || dbg_state !== S_RST) begin
            errors++;
            $display("FAIL %s async_clear: outputs got %h state %0d expected 0 / RST",
                     name, act_vec, dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (act_vec !== '0 || dbg_state !== S_RST) begin
            errors++;
            $display("FAIL %s post_release: outputs got %h state %0d expected 0 / RST",
                     name, act_vec, dbg_state);
        end
        @(negedge clk);
        run_instr(6'h04, 6'h00, 0, 1'b0, "beq_after_reset");
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_exec();
        test_illegal();
        test_back_to_back();
        test_reset_mid(1'b1, "reset_in_exec_wait");
        test_reset_mid(1'b0, "reset_in_fetch");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
